// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, fetch FSM states and the IF/ID payload layout.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
   } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: valid/ready pipeline register with flush; payload holds when empty or stalled.
module if_id_reg import riscv_pkg::*; #(
   parameter logic [ILEN-1:0] RST_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   flush,
   input  logic   in_valid,
   output logic   in_ready,
   input  if_id_t in_data,
   output logic   out_valid,
   input  logic   out_ready,
   output if_id_t out_data
);
   assign in_ready = !out_valid || out_ready;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '{pc: '0, instr: RST_INSTR, pc_plus4: '0};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from instruction memory and feeds decode through IF/ID.
module instr_fetch_unit import riscv_pkg::*; #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 32,
   parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_plus4,
   output logic        fetch_fault
);
   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
   fetch_state_t state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic misaligned, out_of_range, accept, push, flush;
   if_id_t id_q;
   assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
   // range check precedes the increment so a wrapped PC is never captured
   assign out_of_range = pc_q > LAST_PC;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (state_q != FAULT) begin
         state_d = RUN;
         if (misaligned) begin
            state_d = FAULT;
            flush   = 1'b1;
         end else if (redirect_valid) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
         end else if (state_q == RUN && accept) begin
            if (out_of_range) begin
               state_d = FAULT;
               flush   = 1'b1;
            end else begin
               push = 1'b1;
               pc_d = pc_q + 32'd4;
            end
         end
      end
   end
   if_id_reg #(.RST_INSTR(NOP_INSTR)) u_if_id (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (push),
      .in_ready  (accept),
      .in_data   ('{pc: pc_q, instr: imem_instr, pc_plus4: pc_q + 32'd4}),
      .out_valid (id_valid),
      .out_ready (id_ready),
      .out_data  (id_q)
   );
   assign imem_pc     = pc_q;
   assign id_pc       = id_q.pc;
   assign id_instr    = id_q.instr;
   assign id_pc_plus4 = id_q.pc_plus4;
   assign fetch_fault = state_q == FAULT;
endmodule
